// File: rtl/bus_arbiter.sv
// bus_arbiter: registered N-source shared-bus arbiter, fixed-priority or round-robin, with locking.
// Optional conflict detection/counter is enabled by defining BUS_ARB_CONFLICT_DETECT_EN.
module bus_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_SRC  = 5,
    parameter int unsigned MODE   = 0,
    localparam int unsigned OWNER_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_SRC-1:0]          req_i,
    input  logic [N_SRC-1:0]          lock_i,
    input  logic [N_SRC*DATA_W-1:0]   data_i,
    output logic [N_SRC-1:0]          gnt_o,
    output logic [OWNER_W-1:0]        owner_o,
    output logic                      bus_valid_o,
    output logic [DATA_W-1:0]         bus_o,
    output logic                      conflict_o,
    output logic [7:0]                conflict_cnt_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGrant = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    localparam logic [N_SRC-1:0] GntLsb = {{(N_SRC-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [N_SRC-1:0]   gnt_q, gnt_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  bus_q, bus_d;
    logic               bus_valid_q, bus_valid_d;
    logic [OWNER_W-1:0] win_idx;
    logic               win_found;
    logic               hold;
    int                 cand;

    // Candidate order is 0..N-1 for fixed priority, or rotated to start at rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int off = 0; off < int'(N_SRC); off++) begin
            cand = off;
            if (MODE == 1) begin
                cand = int'(rr_ptr_q) + off;
                if (cand >= int'(N_SRC)) cand = cand - int'(N_SRC);
            end
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = OWNER_W'(cand);
            end
        end
    end

    assign hold = (state_q != StIdle) && req_i[owner_q] && lock_i[owner_q];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        bus_d       = bus_q;
        bus_valid_d = 1'b0;
        if (hold) begin
            state_d     = StHold;
            bus_d       = data_i[int'(owner_q)*DATA_W +: DATA_W];
            bus_valid_d = 1'b1;
        end else if (win_found) begin
            state_d     = StGrant;
            owner_d     = win_idx;
            gnt_d       = GntLsb << win_idx;
            bus_d       = data_i[int'(win_idx)*DATA_W +: DATA_W];
            bus_valid_d = 1'b1;
            rr_ptr_d    = (int'(win_idx) == int'(N_SRC) - 1) ? '0 : win_idx + OWNER_W'(1);
        end else begin
            state_d = StIdle;
            owner_d = '0;
            gnt_d   = '0;
            bus_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            bus_q       <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            bus_q       <= bus_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign owner_o     = owner_q;
    assign bus_o       = bus_q;
    assign bus_valid_o = bus_valid_q;

`ifdef BUS_ARB_CONFLICT_DETECT_EN
    logic       multi_req;
    logic       conflict_q;
    logic [7:0] conflict_cnt_q;

    // Counts raw requests, including those blocked by a lock.
    assign multi_req = $countones(req_i) > 1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_q     <= 1'b0;
            conflict_cnt_q <= 8'h00;
        end else begin
            conflict_q <= multi_req;
            if (multi_req && conflict_cnt_q != 8'hFF) conflict_cnt_q <= conflict_cnt_q + 8'd1;
        end
    end

    assign conflict_o     = conflict_q;
    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_o     = 1'b0;
    assign conflict_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: runs a fixed-priority and a round-robin instance side by side against
// a source-level ownership model; conflict expectations follow BUS_ARB_CONFLICT_DETECT_EN.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] lock;
    logic [7:0] dat [5];
    logic [39:0] data_bus;

    logic [4:0] gnt   [2];
    logic [2:0] owner [2];
    logic       valid [2];
    logic [7:0] bus   [2];
    logic       cf    [2];
    logic [7:0] cnt   [2];

    int checks = 0;
    int errors = 0;

    // Reference state: owner index (-1 when idle), round-robin turn, expected bus.
    int         own  [2];
    int         rr   [2];
    logic [7:0] ebus [2];
    logic       ecf;
    int         ecnt;

    always #5 clk = ~clk;

    always_comb data_bus = {dat[4], dat[3], dat[2], dat[1], dat[0]};

    bus_arbiter #(.DATA_W(8), .N_SRC(5), .MODE(0)) u_fp (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .data_i(data_bus),
        .gnt_o(gnt[0]), .owner_o(owner[0]), .bus_valid_o(valid[0]), .bus_o(bus[0]),
        .conflict_o(cf[0]), .conflict_cnt_o(cnt[0])
    );

    bus_arbiter #(.DATA_W(8), .N_SRC(5), .MODE(1)) u_rr (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .data_i(data_bus),
        .gnt_o(gnt[1]), .owner_o(owner[1]), .bus_valid_o(valid[1]), .bus_o(bus[1]),
        .conflict_o(cf[1]), .conflict_cnt_o(cnt[1])
    );

    function automatic int pick(int m);
        for (int k = 0; k < 5; k++) begin
            int i;
            i = (m == 0) ? k : (rr[m] + k) % 5;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                own[m] = -1; rr[m] = 0; ebus[m] = 8'h00;
            end else if (own[m] >= 0 && req[own[m]] && lock[own[m]]) begin
                ebus[m] = dat[own[m]];
            end else begin
                w = pick(m);
                own[m] = w;
                if (w < 0) ebus[m] = 8'h00;
                else begin
                    ebus[m] = dat[w];
                    rr[m] = (w + 1) % 5;
                end
            end
        end
        if (rst) begin
            ecf = 1'b0; ecnt = 0;
        end else begin
            ecf = ($countones(req) > 1);
            if (ecf && ecnt < 255) ecnt = ecnt + 1;
        end
    endtask

    function automatic logic [16:0] exp_pack(int m);
        logic [4:0] g;
        logic [2:0] o;
        logic       v;
        g = 5'b0; o = 3'd0; v = 1'b0;
        if (own[m] >= 0) begin
            g = 5'b00001 << own[m];
            o = 3'(own[m]);
            v = 1'b1;
        end
        return {g, o, v, ebus[m]};
    endfunction

    function automatic logic [8:0] exp_conf();
`ifdef BUS_ARB_CONFLICT_DETECT_EN
        return {ecf, 8'(ecnt)};
`else
        return 9'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 5'b11111; lock = 5'b11111;
        for (int i = 0; i < 2; i++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if ({gnt[m], owner[m], valid[m], bus[m]} !== 17'd0) begin
                    errors++;
                    $display("FAIL reset dut%0d: got %h expected %h", m,
                             {gnt[m], owner[m], valid[m], bus[m]}, 17'd0);
                end
                checks++;
                if ({cf[m], cnt[m]} !== 9'd0) begin
                    errors++;
                    $display("FAIL reset_conflict dut%0d: got %h expected 0", m, {cf[m], cnt[m]});
                end
            end
        end
        rst = 1'b0; req = 5'b0; lock = 5'b0;
    endtask

    task automatic test_fixed_priority();
        dat[1] = 8'h11; dat[2] = 8'h22; dat[4] = 8'h44;
        req = 5'b10110; lock = 5'b0;
        step();
        checks++;
        if ({gnt[0], owner[0], valid[0], bus[0]} !== {5'b00010, 3'd1, 1'b1, 8'h11}) begin
            errors++;
            $display("FAIL fixed_prio_first: got %h expected %h",
                     {gnt[0], owner[0], valid[0], bus[0]}, {5'b00010, 3'd1, 1'b1, 8'h11});
        end
        req = 5'b10100;
        step();
        checks++;
        if ({gnt[0], owner[0], valid[0], bus[0]} !== {5'b00100, 3'd2, 1'b1, 8'h22}) begin
            errors++;
            $display("FAIL fixed_prio_drop: got %h expected %h",
                     {gnt[0], owner[0], valid[0], bus[0]}, {5'b00100, 3'd2, 1'b1, 8'h22});
        end
        checks++;
        if ({gnt[1], owner[1], valid[1], bus[1]} !== exp_pack(1)) begin
            errors++;
            $display("FAIL fixed_prio_rr_model: got %h expected %h",
                     {gnt[1], owner[1], valid[1], bus[1]}, exp_pack(1));
        end
        req = 5'b0;
    endtask

    task automatic test_round_robin();
        int seq [7] = '{0, 1, 2, 3, 4, 0, 1};
        rst = 1'b1; step(); rst = 1'b0;
        req = 5'b11111; lock = 5'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (owner[1] !== 3'(seq[i]) || gnt[1] !== (5'b00001 << seq[i])) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got owner %0d gnt %b expected owner %0d", i,
                         owner[1], gnt[1], seq[i]);
            end
            checks++;
            if ({gnt[0], owner[0], valid[0], bus[0]} !== exp_pack(0)) begin
                errors++;
                $display("FAIL rr_fp_model[%0d]: got %h expected %h", i,
                         {gnt[0], owner[0], valid[0], bus[0]}, exp_pack(0));
            end
        end
        req = 5'b0;
    endtask

    task automatic test_lock();
        rst = 1'b1; step(); rst = 1'b0;
        dat[0] = 8'hA0; dat[3] = 8'h3C;
        req = 5'b01000; lock = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            step();
            req = 5'b01001;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if ({gnt[m], owner[m], valid[m], bus[m]} !== {5'b01000, 3'd3, 1'b1, 8'h3C}) begin
                    errors++;
                    $display("FAIL lock_hold dut%0d cyc%0d: got %h expected %h", m, i,
                             {gnt[m], owner[m], valid[m], bus[m]}, {5'b01000, 3'd3, 1'b1, 8'h3C});
                end
            end
        end
        lock = 5'b0;
        step();
        checks++;
        if ({gnt[0], owner[0], valid[0], bus[0]} !== {5'b00001, 3'd0, 1'b1, 8'hA0}) begin
            errors++;
            $display("FAIL lock_release: got %h expected %h",
                     {gnt[0], owner[0], valid[0], bus[0]}, {5'b00001, 3'd0, 1'b1, 8'hA0});
        end
        checks++;
        if ({gnt[1], owner[1], valid[1], bus[1]} !== exp_pack(1)) begin
            errors++;
            $display("FAIL lock_release_rr: got %h expected %h",
                     {gnt[1], owner[1], valid[1], bus[1]}, exp_pack(1));
        end
        req = 5'b0;
    endtask

    task automatic test_idle_reset();
        req = 5'b0; lock = 5'b0;
        step();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({valid[m], bus[m], gnt[m]} !== 14'd0) begin
                errors++;
                $display("FAIL idle dut%0d: got valid %b bus %h gnt %b expected 0", m,
                         valid[m], bus[m], gnt[m]);
            end
        end
        dat[2] = 8'h5A; req = 5'b00110; lock = 5'b00110;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({gnt[m], owner[m], valid[m], bus[m], cf[m], cnt[m]} !== 26'd0) begin
                errors++;
                $display("FAIL hold_reset dut%0d: got %h expected 0", m,
                         {gnt[m], owner[m], valid[m], bus[m], cf[m], cnt[m]});
            end
        end
        dat[0] = 8'hC3; req = 5'b11111; lock = 5'b0;
        step();
        checks++;
        if ({gnt[1], owner[1], valid[1], bus[1]} !== {5'b00001, 3'd0, 1'b1, 8'hC3}) begin
            errors++;
            $display("FAIL rr_restart: got %h expected %h",
                     {gnt[1], owner[1], valid[1], bus[1]}, {5'b00001, 3'd0, 1'b1, 8'hC3});
        end
        req = 5'b0;
    endtask

    task automatic test_conflict();
        logic [8:0] want;
        rst = 1'b1; step(); rst = 1'b0;
        req = 5'b00011; lock = 5'b0;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef BUS_ARB_CONFLICT_DETECT_EN
            want = {1'b1, 8'(i + 1)};
`else
            want = 9'd0;
`endif
            for (int m = 0; m < 2; m++) begin
                checks++;
                if ({cf[m], cnt[m]} !== want) begin
                    errors++;
                    $display("FAIL conflict_count dut%0d cyc%0d: got %h expected %h", m, i,
                             {cf[m], cnt[m]}, want);
                end
            end
        end
        for (int i = 0; i < 300; i++) step();
`ifdef BUS_ARB_CONFLICT_DETECT_EN
        want = {1'b1, 8'hFF};
`else
        want = 9'd0;
`endif
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({cf[m], cnt[m]} !== want) begin
                errors++;
                $display("FAIL conflict_saturate dut%0d: got %h expected %h", m,
                         {cf[m], cnt[m]}, want);
            end
        end
        req = 5'b0;
        step();
        checks++;
        if ({cf[0], cnt[0]} !== exp_conf()) begin
            errors++;
            $display("FAIL conflict_clear: got %h expected %h", {cf[0], cnt[0]}, exp_conf());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            req  = ($urandom_range(0, 7) == 0) ? 5'b0 : 5'($urandom);
            lock = 5'($urandom);
            for (int s = 0; s < 5; s++) dat[s] = 8'($urandom);
            step();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if ({gnt[m], owner[m], valid[m], bus[m]} !== exp_pack(m)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: got %h expected %h", m, i,
                             {gnt[m], owner[m], valid[m], bus[m]}, exp_pack(m));
                end
                checks++;
                if ({cf[m], cnt[m]} !== exp_conf()) begin
                    errors++;
                    $display("FAIL random_conflict dut%0d cyc%0d: got %h expected %h", m, i,
                             {cf[m], cnt[m]}, exp_conf());
                end
            end
        end
        rst = 1'b0; req = 5'b0; lock = 5'b0;
    endtask

    initial begin
        rst = 1'b1; req = 5'b0; lock = 5'b0;
        for (int s = 0; s < 5; s++) dat[s] = 8'h00;
        own[0] = -1; own[1] = -1; rr[0] = 0; rr[1] = 0;
        ebus[0] = 8'h00; ebus[1] = 8'h00; ecf = 1'b0; ecnt = 0;
        #2;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_idle_reset();
        test_conflict();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
